// File: rtl/conv_complex_stream_out.sv
`default_nettype none
// ============================================================================
//  Module   : conv_complex_stream_out
//  Purpose  : Captures the packed complex convolution result vector and the
//             engine overflow flag on a start request, then replays the
//             result one complex sample per valid/ready handshake, in order,
//             with sample index and last-sample markers.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    QI, QF      integer / fractional bits of a signed word, W = QI + QF
//    NUM_ELEMS   convolution input length; the result holds L = NUM_ELEMS+2
//  Ports
//    clk           in   clock
//    rst           in   asynchronous reset, active low
//    start         in   capture request (engine done)
//    abort         in   synchronous cancel of an in-progress stream
//    conv_in       in   packed result, 2*W*L bits, sample 0 in the top slot
//    overflow_in   in   engine overflow flag, sampled together with conv_in
//    out_ready     in   downstream ready
//    out_valid     out  sample valid
//    out_re        out  real part of the current sample (slot low half)
//    out_im        out  imaginary part of the current sample (slot high half)
//    out_index     out  sample number 0..L-1
//    out_last      out  high together with sample L-1
//    out_overflow  out  captured overflow flag, held until the next capture
//    busy          out  high whenever the block is not idle
//    done          out  one-cycle pulse after the last handshake
// ============================================================================
module conv_complex_stream_out #(
  parameter int QI        = 3,
  parameter int QF        = 3,
  parameter int NUM_ELEMS = 100
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         abort,
  input  logic [2*(QI+QF)*(NUM_ELEMS+2)-1:0]           conv_in,
  input  logic                                         overflow_in,
  input  logic                                         out_ready,
  output logic                                         out_valid,
  output logic [QI+QF-1:0]                             out_re,
  output logic [QI+QF-1:0]                             out_im,
  output logic [$clog2(NUM_ELEMS+2)-1:0]               out_index,
  output logic                                         out_last,
  output logic                                         out_overflow,
  output logic                                         busy,
  output logic                                         done
);

  localparam int W      = QI + QF;
  localparam int L      = NUM_ELEMS + 2;
  localparam int SLOT_W = 2 * W;
  localparam int VEC_W  = SLOT_W * L;
  localparam int IDX_W  = $clog2(L);
  // Lowest bit of the most significant slot: the sample currently presented.
  localparam int TOP_LO = VEC_W - SLOT_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   buf_q,   buf_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               ovf_q,   ovf_d;

  logic               w_streaming;
  logic               w_at_last;
  logic               w_handshake;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decodes from registered state only, so no input reaches an output
  // combinationally; out_valid in particular is independent of out_ready.
  // --------------------------------------------------------------------------
  assign w_streaming = (state_q == ST_STREAM);
  assign w_at_last   = (idx_q == LAST_IDX);
  assign w_handshake = w_streaming && out_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous abort has nothing to cancel here, so start wins.
        if (start) begin
          buf_d   = conv_in;
          ovf_d   = overflow_in;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        // Abort outranks a handshake in the same cycle; start is ignored so
        // the captured vector is never disturbed mid-stream.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (w_handshake) begin
          buf_d = buf_q << SLOT_W;
          if (w_at_last) begin
            // Index stays at L-1 so it never wraps; it is masked off in DONE.
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_DONE: begin
        // The done pulse lasts exactly one cycle whether or not abort is seen.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Sample fields are masked outside STREAM so an aborted stream
  // leaves no stale sample on the bus; the overflow flag is held instead.
  // --------------------------------------------------------------------------
  assign out_valid    = w_streaming;
  assign out_re       = w_streaming ? buf_q[TOP_LO +: W]     : '0;
  assign out_im       = w_streaming ? buf_q[TOP_LO + W +: W] : '0;
  assign out_index    = w_streaming ? idx_q                  : '0;
  assign out_last     = w_streaming && w_at_last;
  assign out_overflow = ovf_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_complex_stream_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_complex_stream_out
//  Purpose  : Self-checking bench for conv_complex_stream_out with L = 6.
//             Expected samples come from per-sample Re/Im arrays that are
//             packed into conv_in by the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_complex_stream_out;

  localparam int QI    = 3;
  localparam int QF    = 3;
  localparam int NE    = 4;
  localparam int W     = QI + QF;
  localparam int L     = NE + 2;
  localparam int VW    = 2 * W * L;
  localparam int IW    = $clog2(L);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [VW-1:0] conv_in;
  logic          overflow_in;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_re;
  logic [W-1:0]  out_im;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_overflow;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference samples for the current capture
  logic [W-1:0] ref_re [L];
  logic [W-1:0] ref_im [L];
  logic         ref_ovf;

  // Beats observed at handshakes
  logic [W-1:0] got_re [$];
  logic [W-1:0] got_im [$];
  int           got_idx[$];
  logic         got_last[$];
  logic         got_ovf[$];
  int           hs_last_cycle;
  int           done_cycle;
  int           done_count;
  int           hold_bad;

  always #5 clk = ~clk;

  conv_complex_stream_out #(
    .QI        (QI),
    .QF        (QF),
    .NUM_ELEMS (NE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .conv_in      (conv_in),
    .overflow_in  (overflow_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_index    (out_index),
    .out_last     (out_last),
    .out_overflow (out_overflow),
    .busy         (busy),
    .done         (done)
  );

  // Sample k lives in slot L-1-k counted from the bottom; Re low, Im high.
  function automatic logic [VW-1:0] pack_ref();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++) begin
      v[2*W*(L-1-k) +: W]     = ref_re[k];
      v[2*W*(L-1-k) + W +: W] = ref_im[k];
    end
    return v;
  endfunction

  task automatic fill_counting(input int re_base, input int im_base);
    for (int k = 0; k < L; k++) begin
      ref_re[k] = W'(re_base + k);
      ref_im[k] = W'(im_base + k);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < L; k++) begin
      ref_re[k] = W'($urandom);
      ref_im[k] = W'($urandom);
    end
  endtask

  // One-cycle start pulse; overflow_in is flipped afterwards so only the
  // captured value can explain out_overflow.
  task automatic capture(input logic ovf);
    @(negedge clk);
    conv_in     = pack_ref();
    overflow_in = ovf;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    overflow_in = ~ovf;
    conv_in     = VW'({$urandom, $urandom, $urandom});
    ref_ovf     = ovf;
  endtask

  // Drives out_ready (0: always, 1: 1,0,0 repeating, 2: random) and records
  // beats; stops two cycles after done or when the budget runs out.
  task automatic collect(input int mode, input int budget);
    logic         prev_stall;
    logic [W-1:0] p_re, p_im;
    logic [IW-1:0] p_idx;
    logic         p_last, p_ovf;
    got_re.delete(); got_im.delete(); got_idx.delete();
    got_last.delete(); got_ovf.delete();
    hs_last_cycle = -1;
    done_cycle    = -1;
    done_count    = 0;
    hold_bad      = 0;
    prev_stall    = 1'b0;
    p_re = '0; p_im = '0; p_idx = '0; p_last = 1'b0; p_ovf = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (prev_stall && (out_valid !== 1'b1 || out_re !== p_re || out_im !== p_im ||
                         out_index !== p_idx || out_last !== p_last ||
                         out_overflow !== p_ovf))
        hold_bad++;
      if (done === 1'b1) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1 && out_ready) begin
        got_re.push_back(out_re);
        got_im.push_back(out_im);
        got_idx.push_back(int'(out_index));
        got_last.push_back(out_last);
        got_ovf.push_back(out_overflow);
        hs_last_cycle = c;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      p_re = out_re; p_im = out_im; p_idx = out_index;
      p_last = out_last; p_ovf = out_overflow;
      @(negedge clk);
      if (done_cycle >= 0 && c >= done_cycle + 1) break;
    end
    out_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    int bad;
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    overflow_in = 1'b1; conv_in = '1;
    #23;
    vectors++;
    if ({out_valid, out_re, out_im, out_index, out_last, out_overflow, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b re=%h im=%h idx=%0d last=%b ovf=%b busy=%b done=%b, need all 0",
               out_valid, out_re, out_im, out_index, out_last, out_overflow, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      conv_in     = VW'({$urandom, $urandom, $urandom});
      overflow_in = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      abort       = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_overflow !== 1'b0) bad++;
    end
    abort = 1'b0; out_ready = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL idle_no_start: %0d cycles with activity, need 0", bad);
    end
  endtask

  task automatic test_full_ready();
    fill_counting(1, 8);
    capture(1'b0);
    collect(0, 20);
    vectors++;
    if (got_re.size() !== L) begin
      miscompares++;
      $display("FAIL full_beats: got %0d handshakes, need %0d", got_re.size(), L);
    end
    for (int k = 0; k < L && k < got_re.size(); k++) begin
      vectors++;
      if (got_re[k] !== ref_re[k] || got_im[k] !== ref_im[k] || got_idx[k] !== k ||
          got_last[k] !== (k == L-1) || got_ovf[k] !== ref_ovf) begin
        miscompares++;
        $display("FAIL full_beat%0d: got re=%h im=%h idx=%0d last=%b ovf=%b, need re=%h im=%h idx=%0d last=%b ovf=%b",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k], got_ovf[k],
                 ref_re[k], ref_im[k], k, (k == L-1), ref_ovf);
      end
    end
    vectors++;
    if (hs_last_cycle !== L-1 || done_cycle !== L || done_count !== 1) begin
      miscompares++;
      $display("FAIL full_timing: got last_hs=%0d done_at=%0d done_cnt=%0d, need %0d %0d 1",
               hs_last_cycle, done_cycle, done_count, L-1, L);
    end
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_idle_after: got busy=%b valid=%b, need 0 0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    fill_counting(1, 8);
    capture(1'b0);
    collect(1, 60);
    vectors++;
    if (got_re.size() !== L || hold_bad !== 0) begin
      miscompares++;
      $display("FAIL bp_beats: got %0d handshakes and %0d unstable stalls, need %0d and 0",
               got_re.size(), hold_bad, L);
    end
    for (int k = 0; k < L && k < got_re.size(); k++) begin
      vectors++;
      if (got_re[k] !== ref_re[k] || got_im[k] !== ref_im[k] || got_idx[k] !== k ||
          got_last[k] !== (k == L-1)) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got re=%h im=%h idx=%0d last=%b, need re=%h im=%h idx=%0d last=%b",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k],
                 ref_re[k], ref_im[k], k, (k == L-1));
      end
    end
    vectors++;
    if (done_count !== 1 || done_cycle !== hs_last_cycle + 1) begin
      miscompares++;
      $display("FAIL bp_done: got done_cnt=%0d done_at=%0d, need 1 at %0d",
               done_count, done_cycle, hs_last_cycle + 1);
    end
  endtask

  task automatic test_overflow();
    int bad;
    fill_counting(3, 30);
    capture(1'b1);
    collect(0, 20);
    bad = 0;
    foreach (got_ovf[k]) if (got_ovf[k] !== 1'b1) bad++;
    vectors++;
    if (got_ovf.size() !== L || bad !== 0) begin
      miscompares++;
      $display("FAIL ovf_set: got %0d beats, %0d without overflow, need %0d and 0",
               got_ovf.size(), bad, L);
    end
    vectors++;
    if (out_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_hold_idle: got %b, need 1", out_overflow);
    end
    fill_counting(5, 17);
    capture(1'b0);
    collect(0, 20);
    bad = 0;
    foreach (got_ovf[k]) if (got_ovf[k] !== 1'b0) bad++;
    vectors++;
    if (got_ovf.size() !== L || bad !== 0 || out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %0d beats, %0d with overflow, idle flag %b, need %0d, 0, 0",
               got_ovf.size(), bad, out_overflow, L);
    end
  endtask

  task automatic test_start_abort();
    int c;
    int bad;
    fill_counting(20, 40);
    capture(1'b0);
    out_ready = 1'b1;
    c = 0;
    while (!(out_valid === 1'b1 && out_index === IW'(2)) && c < 20) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (c >= 20) begin
      miscompares++;
      $display("FAIL sa_reach_idx2: got timeout, need index 2 within 20 cycles");
    end
    start   = 1'b1;
    conv_in = '1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_index !== IW'(3) || out_re !== ref_re[3] || out_im !== ref_im[3]) begin
      miscompares++;
      $display("FAIL sa_start_ignored: got valid=%b idx=%0d re=%h im=%h, need 1 3 %h %h",
               out_valid, out_index, out_re, out_im, ref_re[3], ref_im[3]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL sa_abort: got valid=%b busy=%b done=%b, need 0 0 0", out_valid, busy, done);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL sa_no_done: got %0d cycles with done/valid, need 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int c;
    fill_counting(9, 2);
    capture(1'b1);
    out_ready = 1'b1;
    c = 0;
    while (!(out_valid === 1'b1 && out_index === IW'(4)) && c < 20) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (c >= 20) begin
      miscompares++;
      $display("FAIL ar_reach_idx4: got timeout, need index 4 within 20 cycles");
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_re, out_im, out_index, out_last, out_overflow, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL ar_async_clear: got valid=%b re=%h im=%h idx=%0d last=%b ovf=%b busy=%b done=%b, need all 0",
               out_valid, out_re, out_im, out_index, out_last, out_overflow, busy, done);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fill_random();
    ref_re[0] = 6'b111000;
    ref_im[0] = 6'b100000;
    ref_re[5] = 6'b111111;
    ref_im[5] = 6'b100001;
    capture(1'b0);
    collect(0, 20);
    vectors++;
    if (got_re.size() !== L || done_count !== 1) begin
      miscompares++;
      $display("FAIL ar_restream: got %0d beats done_cnt=%0d, need %0d and 1",
               got_re.size(), done_count, L);
    end
    for (int k = 0; k < L && k < got_re.size(); k++) begin
      vectors++;
      if (got_re[k] !== ref_re[k] || got_im[k] !== ref_im[k] || got_idx[k] !== k ||
          got_last[k] !== (k == L-1) || got_ovf[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL ar_beat%0d: got re=%h im=%h idx=%0d last=%b ovf=%b, need re=%h im=%h idx=%0d last=%b ovf=0",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k], got_ovf[k],
                 ref_re[k], ref_im[k], k, (k == L-1));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      fill_random();
      capture(1'($urandom_range(0, 1)));
      collect(2, 120);
      vectors++;
      if (got_re.size() !== L || done_count !== 1 || hold_bad !== 0 ||
          done_cycle !== hs_last_cycle + 1) begin
        miscompares++;
        $display("FAIL rnd%0d_flow: got beats=%0d done_cnt=%0d stalls_bad=%0d done_at=%0d, need %0d 1 0 %0d",
                 it, got_re.size(), done_count, hold_bad, done_cycle, L, hs_last_cycle + 1);
      end
      for (int k = 0; k < L && k < got_re.size(); k++) begin
        vectors++;
        if (got_re[k] !== ref_re[k] || got_im[k] !== ref_im[k] || got_idx[k] !== k ||
            got_last[k] !== (k == L-1) || got_ovf[k] !== ref_ovf) begin
          miscompares++;
          $display("FAIL rnd%0d_beat%0d: got re=%h im=%h idx=%0d last=%b ovf=%b, need re=%h im=%h idx=%0d last=%b ovf=%b",
                   it, k, got_re[k], got_im[k], got_idx[k], got_last[k], got_ovf[k],
                   ref_re[k], ref_im[k], k, (k == L-1), ref_ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_backpressure();
    test_overflow();
    test_start_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
